// File: rtl/divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// master: the requester (drives start/clear/operands); slave: the divider.
interface divider_if #(
  parameter int WIDTH = 32
);
  logic             op_start;
  logic             op_clear;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             op_done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output op_start, op_clear, dividend, divisor,
    input  busy, op_done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  op_start, op_clear, dividend, divisor,
    output busy, op_done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Operands are captured on an accepted op_start (IDLE or DONE). A zero
// divisor finishes immediately with quotient all ones and remainder equal
// to the dividend.
module divider #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  divider_if.slave dif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_DONE = 3'd2
  } state_t;

  state_t           r_state;
  logic [6:0]       r_cnt;
  logic [WIDTH:0]   r_p;      // partial remainder
  logic [WIDTH-1:0] r_q;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_d;      // captured divisor
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  // The shift takes the whole partial-remainder register. Its top bit is
  // always zero after a restoring step (P < D), so this is the same trial
  // value as shifting only the low WIDTH bits.
  logic [WIDTH+1:0] w_t;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic             w_last;

  assign w_t    = {r_p, r_q[WIDTH-1]};
  assign w_diff = w_t - {2'b00, r_d};
  assign w_ge   = (w_t >= {2'b00, r_d});
  assign w_last = (r_cnt == 7'(WIDTH - 1));

  // Control FSM plus datapath registers; reset beats op_clear beats op_start.
  always_ff @(posedge clk) begin
    if (reset || dif.op_clear) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
      r_p     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (dif.op_start) begin
            r_d   <= dif.divisor;
            r_cnt <= 7'd0;
            if (dif.divisor == '0) begin
              r_q     <= {WIDTH{1'b1}};
              r_p     <= {1'b0, dif.dividend};
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_dbz   <= 1'b1;
            end else begin
              r_q     <= dif.dividend;
              r_p     <= '0;
              r_state <= S_EXEC;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_dbz   <= 1'b0;
            end
          end else begin
            r_state <= r_state;
          end
        end
        S_EXEC: begin
          r_p   <= w_ge ? (WIDTH+1)'(w_diff) : (WIDTH+1)'(w_t);
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 7'd1;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 7'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_dbz   <= 1'b0;
        end
      endcase
    end
  end

  assign dif.busy        = r_busy;
  assign dif.op_done     = r_done;
  assign dif.div_by_zero = r_dbz;
  assign dif.quotient    = r_q;
  assign dif.remainder   = r_p[WIDTH-1:0];

endmodule
